// File: rtl/bcd_pkg.sv
// bcd_pkg: constants and FSM state encoding shared by the double-dabble
// binary-to-BCD converter and its nibble adjust cell.
package bcd_pkg;
  localparam int         NIB_W       = 4;
  localparam int         ADD3_THRESH = 5;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  // FSM states
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: the "add 3" step of double dabble for one BCD digit.
// If the digit is 5 or more, 3 is added so that the following left shift
// carries correctly into the next digit.
//   nib_in  : current digit value
//   nib_out : adjusted digit value (combinational)
import bcd_pkg::*;

module bcd_digit_adjust (
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);
  assign nib_out = (nib_in >= NIB_W'(ADD3_THRESH)) ? nib_in + NIB_W'(3) : nib_in;
endmodule

// File: rtl/bin2bcd_dd_n.sv
// bin2bcd_dd_n: sequential binary-to-BCD converter (shift-and-add-3).
// One bit of the binary input is consumed per clock; a conversion takes
// BIN_W cycles after the accepted start edge.
//   clk, reset_p : clock, asynchronous active-high reset
//   start        : request a conversion of bin_in (ignored while busy)
//   bin_in       : unsigned binary value, captured on an accepted start
//   busy         : conversion in progress
//   done         : one-cycle pulse when results are updated
//   bcd_out      : packed BCD, digit 0 (ones) in the low nibble
//   overflow     : last value did not fit in DIGITS digits (bcd_out = all 9s)
//   blank_mask   : bit i set when digit i is a suppressible leading zero
import bcd_pkg::*;

module bin2bcd_dd_n #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_p,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [NIB_W*DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic [DIGITS-1:0]       blank_mask
);
  localparam int SCR_W = NIB_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Ones digit is never blanked, every higher digit blanked at reset.
  localparam logic [DIGITS-1:0] MASK_RST = {DIGITS{1'b1}} << 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_sh, bin_nxt;
  logic [SCR_W-1:0] scr, adj, scr_nxt;
  logic             ovf, ovf_nxt;
  logic [SCR_W-1:0] res_bcd;
  logic [DIGITS-1:0] res_mask;
  logic             upper_zero;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_adjust u_adj (
        .nib_in  (scr[g*NIB_W +: NIB_W]),
        .nib_out (adj[g*NIB_W +: NIB_W])
      );
    end
  endgenerate

  // One iteration: adjust, then shift {scratch, bin_sh} left by one.
  // The bit falling off the scratch MSB means the value no longer fits.
  assign scr_nxt = {adj[SCR_W-2:0], bin_sh[BIN_W-1]};
  assign bin_nxt = bin_sh << 1;
  assign ovf_nxt = ovf | adj[SCR_W-1];

  // Result of the final iteration, saturated, plus its leading-zero mask.
  always_comb begin
    res_bcd    = ovf_nxt ? {DIGITS{BCD_NINE}} : scr_nxt;
    res_mask   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (res_bcd[i*NIB_W +: NIB_W] == '0);
      res_mask[i] = upper_zero & ~ovf_nxt;
    end
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= IDLE;
      cnt        <= '0;
      bin_sh     <= '0;
      scr        <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      blank_mask <= MASK_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sh <= bin_in;
            scr    <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          scr    <= scr_nxt;
          bin_sh <= bin_nxt;
          ovf    <= ovf_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd_out    <= res_bcd;
            overflow   <= ovf_nxt;
            blank_mask <= res_mask;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bin2bcd_dd_n.md
# bin2bcd_dd_n

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It is generic in binary width and output digit count, and uses a start/busy/done handshake. It sits between counters and the FND display driver, replacing per-digit divide/modulo logic. It also adds three things the divide/modulo approach lacks: overflow detection with saturation, a leading-zero blank mask, and a multi-cycle datapath with no divider.

## Interface
- BIN_W, 14: width of binary input; ≥ 1.
- DIGITS, 4: number of BCD output digits; ≥ 1.
- clk  in  1  system clock; all state changes on rising edge.
- reset_p  in  1  reset, asynchronous, active-high.
- start  in  1  request conversion of bin_in; sampled on the rising edge of clk.
- bin_in  in  BIN_W  unsigned binary value; captured only on an accepted start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; results valid.
- bcd_out  out  4*DIGITS  packed BCD; digit i at bits [4i+3:4i]; digit 0 = ones.
- overflow  out  1  last result ≥ 10^DIGITS.
- blank_mask  out  DIGITS  bit i = 1 when digit i is a suppressible leading zero.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE, start=1 → capture bin_in into the shift register, clear the BCD scratch, clear the ovf flag, load iteration count = BIN_W, go to SHIFT.
- IDLE, start=0 → hold all state.
- SHIFT, each cycle, as one iteration:
  - every scratch nibble ≥ 5 gets +3;
  - then {scratch, bin_shift} shifts left by 1;
  - the bit leaving the scratch MSB is ORed into ovf;
  - count decrements by 1.
- SHIFT, final iteration (count = 1) → register the results, pulse done, return to IDLE.
- Result registration:
  - ovf = 0 → bcd_out = final scratch, overflow = 0.
  - ovf = 1 → bcd_out saturates to all nibbles 4'h9, overflow = 1.
- blank_mask rules, computed from the registered bcd_out at result registration:
  - bit 0 is always 0;
  - bit i (i ≥ 1) = 1 iff digits i..DIGITS-1 are all zero;
  - when overflow = 1, blank_mask = 0.
- start while busy = 1 is ignored; no queuing.
- bcd_out, overflow and blank_mask hold their values until the next done.
- Arithmetic:
  - the scratch register is exactly 4*DIGITS bits;
  - there is no internal wider accumulation;
  - overflow is detected solely by bits shifted out of the scratch MSB.

## Timing
- Reset values: busy = 0, done = 0, bcd_out = 0, overflow = 0, blank_mask = {DIGITS-1 ones, 1'b0}, FSM = IDLE.
- Start edge E0 (start = 1 sampled in IDLE) → busy = 1 after E0.
- Iterations occur on edges E1..E_BIN_W.
- At E_BIN_W: outputs updated, done = 1, busy = 0. Latency is BIN_W cycles from E0.
- done is high for exactly one cycle, after E_BIN_W and cleared at E_BIN_W+1.
- start may be asserted during the done cycle; it is accepted at E_BIN_W+1. Back-to-back throughput is one result per BIN_W+1 cycles.
- reset_p mid-conversion → immediate return to reset values; no done pulse; a partial result is never exposed.
- Outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `bcd_pkg` holds:
  - NIB_W = 4;
  - ADD3_THRESH = 5;
  - BCD_NINE = 4'h9;
  - state encoding (IDLE, SHIFT).
- Sub-module `bcd_digit_adjust`: combinational 4-bit nibble in → nibble + 3 if ≥ 5, else unchanged.
  - The top level instantiates it DIGITS times in a generate loop.
- Iteration counter width = $clog2(BIN_W+1).

## Test plan
- Defaults; bin_in = 1234, start pulse → done exactly 14 cycles after the start edge; bcd_out = 16'h1234, overflow = 0, blank_mask = 4'b0000.
- bin_in = 0 → bcd_out = 16'h0000, blank_mask = 4'b1110. bin_in = 42 → 16'h0042, blank_mask = 4'b1100.
- bin_in = 9999 → 16'h9999, overflow = 0. bin_in = 16383 → 16'h9999, overflow = 1, blank_mask = 4'b0000.
- start re-pulsed at cycles 3 and 7 of a conversion of 500 → ignored; a single done with 16'h0500. start held during the done cycle with bin_in = 77 → second done after 14 more cycles, 16'h0077.
- reset_p asserted at cycle 6 of a conversion of 8888 → busy = 0 and outputs = reset values immediately; no done pulse. A later conversion of 8888 completes correctly.
- BIN_W = 20, DIGITS = 6; bin_in = 999999 → 24'h999999, done after 20 cycles. bin_in = 1000000 → saturated, overflow = 1.
